// File: rtl/vram2_fetch.sv
// vram2_fetch: streams a run of 2bpp pixel indices out of an 8Kx2 video RAM.
// A start request latches a base address and pixel count; the block then
// issues sequential reads (address wraps 8191 -> 0), captures the read data
// one cycle later into a small pixel FIFO and presents pixels downstream
// with a valid/ready handshake. Reads are throttled so that FIFO occupancy
// plus the read in flight never exceeds FIFO_DEPTH, so no read data is lost.
//
// Optional feature: define VRAM2_FETCH_PIXEL_DOUBLE_EN to present every FIFO
// entry for two handshakes (horizontal pixel doubling).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle run request (ignored while busy)
//   base_addr  first RAM address of the run
//   count      number of RAM entries to fetch (0 gives an immediate done)
//   busy       run in progress
//   done       one-cycle pulse at end of run
//   ram_en     RAM read enable
//   ram_addr   RAM read address
//   ram_do     RAM read data, valid one cycle after ram_en
//   px_valid   pixel available
//   px_ready   downstream accepts pixel
//   px_data    pixel index
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads until remaining reaches 0
// DRAIN | reads done, waiting for the FIFO to empty
module vram2_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] base_addr,
  input  logic [9:0]  count,
  output logic        busy,
  output logic        done,
  output logic        ram_en,
  output logic [12:0] ram_addr,
  input  logic [1:0]  ram_do,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [1:0]  px_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [12:0]    addr_q, addr_d;
  logic [9:0]     remaining_q, remaining_d;
  logic           inflight_q, inflight_d;
  logic           done_q, done_d;
  logic [1:0]     mem_q [FIFO_DEPTH];
  logic [1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  occ;
  logic           push, pop, handshake, drain_empty;
`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
  logic           second_q, second_d;
`endif

  assign ram_addr  = addr_q;
  assign done      = done_q;
  assign px_valid  = (cnt_q != '0);
  assign px_data   = mem_q[rd_ptr_q];
  assign handshake = px_valid & px_ready;
  // Read data always lands in the cycle after ram_en; the in-flight flag is
  // the write strobe, so clearing it on reset discards a late ram_do.
  assign push      = inflight_q;
  assign occ       = cnt_q + {{AW{1'b0}}, inflight_q};

`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
  assign pop = handshake & second_q;
`else
  assign pop = handshake;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && count != 10'd0) state_d = S_FETCH;
      S_FETCH: if (ram_en && remaining_q == 10'd1) state_d = S_DRAIN;
      S_DRAIN: if (drain_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    ram_en = (state_q == S_FETCH) && (remaining_q != 10'd0) &&
             (occ < CW'(FIFO_DEPTH));
  end

  // datapath
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    inflight_d  = ram_en;
`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
    second_d    = handshake ? ~second_q : second_q;
`endif

    if (state_q == S_IDLE && start && count != 10'd0) begin
      addr_d      = base_addr;
      remaining_d = count;
    end else if (ram_en) begin
      addr_d      = addr_q + 13'd1;
      remaining_d = remaining_q - 10'd1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = ram_do;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A read still in flight always pushes, so an empty next-cycle FIFO in
    // DRAIN means nothing is left. Using next-cycle occupancy lets done land
    // right after the final handshake.
    drain_empty = (state_q == S_DRAIN) && (cnt_d == '0);
    done_d      = (state_q == S_IDLE && start && count == 10'd0) || drain_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
      second_q    <= 1'b0;
`endif
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
      second_q    <= second_d;
`endif
    end
  end

endmodule

// File: tb/tb_vram2_fetch.sv
// Self-checking bench for vram2_fetch: randomized runs against a queue-based
// reference model (expected read addresses and pixel stream per run), plus
// directed boundary runs: address wrap, back-pressure, zero count, reset
// mid-run and start during reset.
module tb_vram2_fetch;
  localparam int DEPTH = 4;
`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
  localparam int MUL = 2;
`else
  localparam int MUL = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, start, px_ready;
  logic [12:0] base_addr;
  logic [9:0]  count;
  logic        busy, done, ram_en, px_valid;
  logic [12:0] ram_addr;
  logic [1:0]  ram_do, px_data;

  vram2_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_do(ram_do), .px_valid(px_valid),
    .px_ready(px_ready), .px_data(px_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous read, garbage on idle cycles
  logic [1:0] ram [8192];
  always @(posedge clk) ram_do <= ram_en ? ram[ram_addr] : 2'($urandom);

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  // reference model state
  int exp_px[$];
  int exp_addr[$];
  int got_px[$];
  int done_cnt = 0, hs_cnt = 0, ren_cnt = 0, busy_cnt = 0;
  int first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  int s_cyc, stall_reads, run_busy;
  logic p_valid = 0, p_ready = 0, p_busy = 0, p_reset = 1;
  logic [1:0]  p_data = 0;
  logic [12:0] p_addr = 0;

  always @(negedge clk) begin
    int e;
    if (reset) begin
      exp_px.delete();
      exp_addr.delete();
      p_reset = 1'b1;
    end else begin
      if (!p_reset && p_valid && !p_ready) begin
        check("px_hold_valid", px_valid, 1);
        check("px_hold_data", px_data, p_data);
      end
      if (!p_reset && !p_busy && !busy) check("ram_addr_hold", ram_addr, p_addr);
      if (ram_en) begin
        ren_cnt++;
        e = (exp_addr.size() != 0) ? exp_addr.pop_front() : -1;
        check("ram_addr", ram_addr, e);
      end
      if (px_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (px_valid && px_ready) begin
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        got_px.push_back(px_data);
        e = (exp_px.size() != 0) ? exp_px.pop_front() : -1;
        check("px_data", px_data, e);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      p_reset = 1'b0;
    end
    p_valid = px_valid; p_ready = px_ready; p_data = px_data;
    p_busy = busy; p_addr = ram_addr;
  end

  task automatic expect_run(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int a;
      a = (base + i) % 8192;
      exp_addr.push_back(a);
      for (int m = 0; m < MUL; m++) exp_px.push_back(ram[a]);
    end
  endtask

  task automatic run(input int base, input int cnt, input int pct, input int stall);
    int k, d0, hs0, r0, b0, bound;
    expect_run(base, cnt);
    got_px.delete();
    first_valid_cyc = -1; first_hs_cyc = -1; stall_reads = -1;
    d0 = done_cnt; hs0 = hs_cnt; r0 = ren_cnt; b0 = busy_cnt;
    bound = 200 + stall + cnt * MUL * 50;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'(base); count = 10'(cnt);
    px_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < pct);
    s_cyc = cyc;
    k = 0;
    forever begin
      @(negedge clk);
      if (done_cnt != d0 || k >= bound) break;
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (k == stall) stall_reads = ren_cnt - r0;
      px_ready = (k < stall) ? 1'b0 : ($urandom_range(99) < pct);
    end
    check("run_done", done_cnt - d0, 1);
    check("run_pixels", hs_cnt - hs0, cnt * MUL);
    check("run_reads", ren_cnt - r0, cnt);
    check("run_px_left", exp_px.size(), 0);
    check("run_addr_left", exp_addr.size(), 0);
    run_busy = busy_cnt - b0;
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, b0, hs0, base;
    for (int i = 0; i < 8192; i++) ram[i] = 2'($urandom);
    for (int i = 'h100; i < 'h110; i++) ram[i] = 2'(i % 4);
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; px_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_data", px_data, 0);
    @(posedge clk); #1; reset = 1'b0;

    // base 0x0100, count 8, ready always: pixels 0,1,2,3,... back to back
    run('h100, 8, 100, 0);
    check("seq_len", got_px.size(), 8 * MUL);
    for (int i = 0; i < got_px.size(); i++) check("seq_px", got_px[i], (i / MUL) % 4);
    check("seq_first_valid", first_valid_cyc - s_cyc, 3);
    check("seq_back_to_back", last_hs_cyc - first_hs_cyc, 8 * MUL - 1);
    check("seq_done_after_last", done_cyc - last_hs_cyc, 1);

    // address wrap 1FFE -> 0001
    run('h1FFE, 4, 100, 0);
    check("wrap_addr_after", ram_addr, 'h0002);

    // back-pressure: ready low for 20 cycles, reads stop at FIFO depth
    run($urandom_range(8191), 16, 100, 20);
    check("stall_reads", stall_reads, DEPTH);

    // count 0: done next cycle, no busy, no reads
    r0 = ren_cnt;
    run($urandom_range(8191), 0, 100, 0);
    check("zero_done_cyc", done_cyc - s_cyc, 1);
    check("zero_busy", run_busy, 0);
    check("zero_reads", ren_cnt - r0, 0);

`ifdef VRAM2_FETCH_PIXEL_DOUBLE_EN
    ram[300] = 2'd1; ram[301] = 2'd2; ram[302] = 2'd3;
    run(300, 3, 100, 0);
    check("dbl_len", got_px.size(), 6);
    for (int i = 0; i < got_px.size(); i++) check("dbl_px", got_px[i], i / 2 + 1);
`endif

    // reset three cycles into a 10-pixel run
    base = $urandom_range(8191);
    expect_run(base, 10);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'(base); count = 10'd10; px_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ram_en", ram_en, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_px_valid", px_valid, 0);
    check("abort_px_data", px_data, 0);
    hs0 = hs_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_pixels", hs_cnt - hs0, 0);
    run($urandom_range(8191), 10, 100, 0);

    // start during reset is ignored
    d0 = done_cnt; r0 = ren_cnt; b0 = busy_cnt;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; base_addr = 13'h0123; count = 10'd5;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_start_busy", busy_cnt - b0, 0);
    check("rst_start_reads", ren_cnt - r0, 0);
    check("rst_start_done", done_cnt - d0, 0);

    // randomized runs, some near the top of the address space
    for (int r = 0; r < 16; r++) begin
      base = (r % 4 == 0) ? 8192 - $urandom_range(1, 20) : $urandom_range(8191);
      run(base, $urandom_range(1, 40), $urandom_range(30, 100), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
